lsu_mem_master: RTL
===================

// Module: lsu_mem_master
// PURPOSE
//  Load/store initiator between the core's execute stage and a word-organised data memory.
//  Accepts one load/store per handshake, drives byte lanes, byte enables and word addresses.
//  Collects read data, then sign/zero-extends it.
//  Multi-cycle, one outstanding access; the core stalls on req_ready=0.
//  Byte order is little-endian throughout: byte at addr[1:0]=0 is bits [7:0].
// PARAMETERS
//  ADDR_W  32  byte address width on core and memory sides
//  DATA_W  32  data width; fixed at 32 (RV32), checked at elaboration
// PORTS
//  clk         in   1       clock, rising edge
//  rst         in   1       synchronous reset, active-high
//  req_valid   in   1       core presents access
//  req_ready   out  1       block idle, can accept
//  req_store   in   1       1=store, 0=load
//  req_funct3  in   3       RV32 funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu
//  req_addr    in   ADDR_W  byte address (ALU result)
//  req_wdata   in   DATA_W  store data, value in low bits
//  resp_valid  out  1       one-cycle completion pulse
//  resp_rdata  out  DATA_W  extended load data (0 for stores/errors)
//  resp_err    out  1       illegal funct3 or misaligned (see CONFIGURATION)
//  mem_req     out  1       memory request, held until mem_gnt
//  mem_we      out  1       write strobe
//  mem_addr    out  ADDR_W  word-aligned address ([1:0]=00)
//  mem_be      out  4       byte enables
//  mem_wdata   out  DATA_W  lane-aligned write data
//  mem_gnt     in   1       memory accepts request this cycle
//  mem_rvalid  in   1       read data valid (reads only, >=1 cycle after gnt)
//  mem_rdata   in   DATA_W  read word
// BEHAVIOUR
//  - Reset: state IDLE; req_ready=1; resp_valid=0, resp_rdata=0, resp_err=0; mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0.
//  - Accept: req_valid&req_ready at edge T registers all req_* fields. req_ready=1 only in IDLE.
//  - FSM: IDLE -> REQ0 -> (load) WAIT0 -> [REQ1 -> WAIT1] -> RESP -> IDLE.
//    Stores go REQn -> next on gnt, with no WAIT. Illegal requests go IDLE -> RESP with err=1 and no bus access.
//  - Illegal: funct3 011/110/111, or store with funct3[2]=1.
//  - mem_req and all mem_* outputs come from registers and are stable while mem_req=1 and gnt=0.
//    mem_req drops in the cycle after gnt.
//  - Byte enables: b = 0001<<a[1:0]; h = 0011<<a[1:0]; w = 1111. Write data is shifted left by 8*a[1:0].
//  - Read: lanes are selected by a[1:0]. b/h are sign-extended from bit 7/15; bu/hu are zero-extended.
//  - mem_rvalid/mem_gnt outside the matching state are ignored.
//  - Latency, aligned load, gnt in the same cycle, rvalid next: accept T, mem_req T+1, rvalid T+2, resp_valid T+3.
//    Aligned store: resp_valid T+2.
//  - resp_valid is high exactly one cycle. resp_* hold their value until the next response.
//  - Reset mid-operation: returns to IDLE next cycle. mem_req deasserts with no response. Late rvalid is dropped.
//  - A second word address (split) = first + 4, modulo 2^ADDR_W (wraps 0xFFFFFFFC -> 0x0).
// CONFIGURATION
//  LSU_MISALIGN_SPLIT_EN defined:
//   - An h at a[1:0]=11 or a w at a[1:0]!=00 splits into two word transactions.
//   - Low part: lanes a[1:0]..3 of word A. High part: remaining lanes 0.. of word A+4.
//   - Load data is assembled before extension. Response follows the second transaction.
//  Not defined:
//   - These accesses complete as IDLE -> RESP with resp_err=1, no mem_req.
//   - REQ1/WAIT1 are removed.
// STRUCTURE
//  - Package lsu_pkg: typedef enum lsu_state_e {IDLE,REQ0,WAIT0,REQ1,WAIT1,RESP}.
//  - lsu_pkg also holds funct3 localparams F3_B/H/W/BU/HU and function be_for(funct3, off).
//  - Sub-module lsu_align: purely combinational. It shifts store data into lanes, merges the two read words, then extracts and extends.
// TESTING
//  1. Load w @0x100, mem_rdata 0xDEADBEEF, gnt immediate -> resp_rdata 0xDEADBEEF at T+3, be=1111, err=0.
//  2. Load b @0x103, word 0x80FF0000 -> 0xFFFFFF80. Load bu, same -> 0x00000080. mem_be=1000 both.
//  3. Store h @0x102, wdata 0x1234ABCD -> mem_addr 0x100, be=1100, mem_wdata[31:16]=0xABCD, we=1. resp at T+2.
//  4. Load w @0x0FE, words 0x2211xxxx @0x0FC and xxxx4433 @0x100 -> rdata 0x44332211 (macro on).
//     Macro off -> err=1, rdata=0, no mem_req.
//  5. gnt held low 5 cycles -> mem_* stable. rst during wait -> mem_req=0, req_ready=1 next cycle, no resp_valid.
//  6. funct3=011 load, or store funct3=100 -> resp_valid with err=1 at T+1, mem_req never asserted.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: FSM states, RV32 load/store funct3 codes and the byte-enable helper shared by the LSU.
package lsu_pkg;

  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Returns an 8-lane span: [3:0] lanes of word A, [7:4] lanes of word A+4.
  function automatic logic [7:0] be_for(input logic [2:0] funct3, input logic [1:0] off);
    logic [7:0] base;
    case (funct3)
      F3_B, F3_BU: base = 8'b0000_0001;
      F3_H, F3_HU: base = 8'b0000_0011;
      default:     base = 8'b0000_1111;
    endcase
    return base << off;
  endfunction

endpackage

// File: rtl/lsu_mem_master_align.sv
// lsu_align: combinational lane steering; shifts store data into lanes, merges two read words,
// then extracts and sign/zero-extends the loaded value.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        st_off,
  input  logic [DATA_W-1:0] st_wdata,
  input  logic              st_hi,
  output logic [DATA_W-1:0] st_lanes,
  input  logic [2:0]        ld_funct3,
  input  logic [1:0]        ld_off,
  input  logic [DATA_W-1:0] rword_lo,
  input  logic [DATA_W-1:0] rword_hi,
  output logic [DATA_W-1:0] ld_data
);

  logic [2*DATA_W-1:0] st_span;
  logic [DATA_W-1:0]   merged;

  always_comb begin
    st_span  = {{DATA_W{1'b0}}, st_wdata} << {st_off, 3'b000};
    st_lanes = st_hi ? st_span[2*DATA_W-1:DATA_W] : st_span[DATA_W-1:0];
    merged   = DATA_W'({rword_hi, rword_lo} >> {ld_off, 3'b000});
    case (ld_funct3)
      F3_B:    ld_data = {{(DATA_W-8){merged[7]}}, merged[7:0]};
      F3_H:    ld_data = {{(DATA_W-16){merged[15]}}, merged[15:0]};
      F3_BU:   ld_data = {{(DATA_W-8){1'b0}}, merged[7:0]};
      F3_HU:   ld_data = {{(DATA_W-16){1'b0}}, merged[15:0]};
      default: ld_data = merged;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: RV32 load/store initiator toward a word-organised data memory, one access in flight.
// Define LSU_MISALIGN_SPLIT_EN to split misaligned h/w accesses into two word transactions.
//  state | meaning
//  IDLE  | ready, accepts a request
//  REQ0  | first (or only) word request on the bus
//  WAIT0 | load waiting for first read word
//  REQ1  | second word request of a split access
//  WAIT1 | load waiting for second read word
//  RESP  | registering the response pulse
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  if (DATA_W != 32) begin : g_data_w_check
    $error("lsu_mem_master: DATA_W must be 32");
  end

  lsu_state_e        state_q, state_d;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic              store_q, err_q;
  logic [DATA_W-1:0] rword0_q, rword_hi;
  logic              bad_f3, misalign, acc_err, split_cur;
  logic [1:0]        st_off;
  logic [DATA_W-1:0] st_wdata, st_lanes, ld_data;
  logic              st_hi;

`ifdef LSU_MISALIGN_SPLIT_EN
  logic              split_q;
  logic [DATA_W-1:0] wdata_q, rword1_q;
  logic [ADDR_W-1:0] addr_next;
  logic [3:0]        be_hi;

  assign acc_err   = bad_f3;
  assign split_cur = split_q;
  assign st_off    = (state_q == IDLE) ? req_addr[1:0] : off_q;
  assign st_wdata  = (state_q == IDLE) ? req_wdata : wdata_q;
  assign st_hi     = (state_q != IDLE);
  assign rword_hi  = rword1_q;
  assign addr_next = {mem_addr[ADDR_W-1:2] + {{(ADDR_W-3){1'b0}}, 1'b1}, 2'b00};
  assign be_hi     = 4'(be_for(f3_q, off_q) >> 4);
`else
  assign acc_err   = bad_f3 | misalign;
  assign split_cur = 1'b0;
  assign st_off    = req_addr[1:0];
  assign st_wdata  = req_wdata;
  assign st_hi     = 1'b0;
  assign rword_hi  = '0;
`endif

  lsu_align #(.DATA_W(DATA_W)) u_align (
    .st_off    (st_off),
    .st_wdata  (st_wdata),
    .st_hi     (st_hi),
    .st_lanes  (st_lanes),
    .ld_funct3 (f3_q),
    .ld_off    (off_q),
    .rword_lo  (rword0_q),
    .rword_hi  (rword_hi),
    .ld_data   (ld_data)
  );

  always_comb begin
    bad_f3   = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) || (req_store && req_funct3[2]);
    misalign = ((req_funct3[1:0] == 2'b01) && (req_addr[1:0] == 2'b11)) ||
               ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00));
    req_ready = (state_q == IDLE);
    state_d   = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = acc_err ? RESP : REQ0;
      REQ0:    if (mem_gnt) state_d = !store_q ? WAIT0 : (split_cur ? REQ1 : RESP);
      WAIT0:   if (mem_rvalid) state_d = split_cur ? REQ1 : RESP;
`ifdef LSU_MISALIGN_SPLIT_EN
      REQ1:    if (mem_gnt) state_d = store_q ? RESP : WAIT1;
      WAIT1:   if (mem_rvalid) state_d = RESP;
`endif
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f3_q <= '0; off_q <= '0; store_q <= 1'b0; err_q <= 1'b0; rword0_q <= '0;
      resp_valid <= 1'b0; resp_rdata <= '0; resp_err <= 1'b0;
      mem_req <= 1'b0; mem_we <= 1'b0; mem_addr <= '0; mem_be <= '0; mem_wdata <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
      split_q <= 1'b0; wdata_q <= '0; rword1_q <= '0;
`endif
    end else begin
      resp_valid <= 1'b0;
      case (state_q)
        IDLE: if (req_valid) begin
          f3_q    <= req_funct3;
          off_q   <= req_addr[1:0];
          store_q <= req_store;
          err_q   <= acc_err;
`ifdef LSU_MISALIGN_SPLIT_EN
          split_q <= misalign;
          wdata_q <= req_wdata;
`endif
          if (!acc_err) begin
            mem_req   <= 1'b1;
            mem_we    <= req_store;
            mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
            mem_be    <= 4'(be_for(req_funct3, req_addr[1:0]));
            mem_wdata <= st_lanes;
          end
        end
        REQ0: if (mem_gnt) begin
          mem_req <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
          // Split store: second word goes out back-to-back with mem_req held high.
          if (store_q && split_q) begin
            mem_req   <= 1'b1;
            mem_addr  <= addr_next;
            mem_be    <= be_hi;
            mem_wdata <= st_lanes;
          end
`endif
        end
        WAIT0: if (mem_rvalid) begin
          rword0_q <= mem_rdata;
`ifdef LSU_MISALIGN_SPLIT_EN
          if (split_q) begin
            mem_req  <= 1'b1;
            mem_addr <= addr_next;
            mem_be   <= be_hi;
          end
`endif
        end
`ifdef LSU_MISALIGN_SPLIT_EN
        REQ1:  if (mem_gnt) mem_req <= 1'b0;
        WAIT1: if (mem_rvalid) rword1_q <= mem_rdata;
`endif
        RESP: begin
          resp_valid <= 1'b1;
          resp_err   <= err_q;
          resp_rdata <= (err_q || store_q) ? '0 : ld_data;
        end
        default: ;
      endcase
    end
  end

endmodule
